// File: rtl/step_tracker_if.sv
// rtl/step_tracker_if.sv - handshake/status bundle between counter-code source and step_tracker
//   lsb, msb : upstream 2-bit counter code {msb, lsb}
//   clear    : synchronous clear of position/fault
//   position : accumulated wrapping step count
//   dir      : direction of last legal step (0 up, 1 down)
//   step     : one-cycle pulse per legal step
//   wrap     : one-cycle pulse when position wraps
//   error    : sticky illegal-transition flag
interface step_tracker_if #(
  parameter int WIDTH = 8
);
  logic             lsb;
  logic             msb;
  logic             clear;
  logic [WIDTH-1:0] position;
  logic             dir;
  logic             step;
  logic             wrap;
  logic             error;

  modport master (
    output lsb, msb, clear,
    input  position, dir, step, wrap, error
  );

  modport slave (
    input  lsb, msb, clear,
    output position, dir, step, wrap, error
  );
endinterface

// File: rtl/step_tracker.sv
// rtl/step_tracker.sv - decodes 2-bit up/down counter code transitions into a wrapping position
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : step_tracker_if slave (code in, clear in, position/dir/step/wrap/error out)
module step_tracker #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  step_tracker_if.slave bus
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_PRIME = 2'd1,
    S_TRACK = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t           r_state;
  logic [1:0]       r_code_q;
  logic [1:0]       r_code_p;
  logic [WIDTH-1:0] r_position;
  logic             r_dir;
  logic             r_step;
  logic             r_wrap;
  logic             r_error;

  // Modulo-4 difference between the current and previous code: 1 = up, 3 = down, 2 = illegal.
  logic [1:0]       w_delta;
  assign w_delta = r_code_q - r_code_p;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_RESET;
      r_code_q   <= 2'b00;
      r_code_p   <= 2'b00;
      r_position <= '0;
      r_dir      <= 1'b0;
      r_step     <= 1'b0;
      r_wrap     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_code_q <= {bus.msb, bus.lsb};
      r_step   <= 1'b0;
      r_wrap   <= 1'b0;
      // The reset edge only captures the code; every later edge shifts it into the history.
      if (r_state != S_RESET) begin
        r_code_p <= r_code_q;
      end
      if (bus.clear) begin
        // Clear wins over any decode this edge; dir is intentionally kept.
        r_position <= '0;
        r_error    <= 1'b0;
        r_state    <= S_PRIME;
      end else begin
        case (r_state)
          S_RESET: r_state <= S_PRIME;
          S_PRIME: r_state <= S_TRACK;
          S_TRACK: begin
            case (w_delta)
              2'd1: begin
                r_position <= r_position + 1'b1;
                r_dir      <= 1'b0;
                r_step     <= 1'b1;
                r_wrap     <= (r_position == {WIDTH{1'b1}});
              end
              2'd3: begin
                r_position <= r_position - 1'b1;
                r_dir      <= 1'b1;
                r_step     <= 1'b1;
                r_wrap     <= (r_position == {WIDTH{1'b0}});
              end
              2'd2: begin
                r_error <= 1'b1;
                r_state <= S_FAULT;
              end
              default: ;
            endcase
          end
          S_FAULT: begin
            r_error <= 1'b1;
            r_state <= S_FAULT;
          end
          default: r_state <= S_RESET;
        endcase
      end
    end
  end

  assign bus.position = r_position;
  assign bus.dir      = r_dir;
  assign bus.step     = r_step;
  assign bus.wrap     = r_wrap;
  assign bus.error    = r_error;

endmodule

// File: tb/tb_step_tracker.sv
// tb/tb_step_tracker.sv - self-checking bench for step_tracker
module tb_step_tracker;

  localparam int WIDTH = 8;
  localparam int MOD   = 1 << WIDTH;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  int   n_steps;
  int   n_wraps;

  step_tracker_if #(.WIDTH(WIDTH)) bus ();

  step_tracker #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: expected outputs from input history. Decoding uses the inputs seen one and
  // two edges earlier, and only once at least two edges have passed since reset
  // (or one since clear).
  int         m_pos;
  logic       m_dir;
  logic       m_step;
  logic       m_wrap;
  logic       m_err;
  int         m_age;
  logic [1:0] m_in1;
  logic [1:0] m_in2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos  = 0;
      m_dir  = 1'b0;
      m_step = 1'b0;
      m_wrap = 1'b0;
      m_err  = 1'b0;
      m_age  = 0;
      m_in1  = 2'b00;
      m_in2  = 2'b00;
    end else begin
      logic [1:0] d;
      d      = m_in1 - m_in2;
      m_step = 1'b0;
      m_wrap = 1'b0;
      if (bus.clear) begin
        m_pos = 0;
        m_err = 1'b0;
        m_age = 1;
      end else begin
        if (m_age >= 2 && !m_err) begin
          if (d == 2'd1) begin
            m_step = 1'b1;
            m_dir  = 1'b0;
            m_wrap = (m_pos + 1 == MOD);
            m_pos  = (m_pos + 1) % MOD;
          end else if (d == 2'd3) begin
            m_step = 1'b1;
            m_dir  = 1'b1;
            m_wrap = (m_pos == 0);
            m_pos  = (m_pos + MOD - 1) % MOD;
          end else if (d == 2'd2) begin
            m_err = 1'b1;
          end
        end
        if (m_age < 2) m_age = m_age + 1;
      end
      m_in2 = m_in1;
      m_in1 = {bus.msb, bus.lsb};
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("position", int'(bus.position), m_pos);
    chk("dir", int'(bus.dir), int'(m_dir));
    chk("step", int'(bus.step), int'(m_step));
    chk("wrap", int'(bus.wrap), int'(m_wrap));
    chk("error", int'(bus.error), int'(m_err));
    if (bus.step === 1'b1) n_steps++;
    if (bus.wrap === 1'b1) n_wraps++;
  end

  task automatic drive(input logic [1:0] c);
    @(negedge clk);
    {bus.msb, bus.lsb} = c;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pulse_clear(input logic [1:0] c);
    @(negedge clk);
    bus.clear = 1'b1;
    {bus.msb, bus.lsb} = c;
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  int s0;
  int w0;

  initial begin
    n_chk = 0; n_fail = 0; n_steps = 0; n_wraps = 0;
    rst_n = 1'b0;
    bus.lsb = 1'b0; bus.msb = 1'b0; bus.clear = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Hold 00 for 5 cycles after reset: nothing moves.
    idle(5);
    chk("rst_pos", int'(bus.position), 0);
    chk("rst_err", int'(bus.error), 0);
    chk("rst_steps", n_steps, 0);

    // Four up steps.
    s0 = n_steps; w0 = n_wraps;
    drive(2'b01); drive(2'b10); drive(2'b11); drive(2'b00);
    idle(3);
    chk("up4_pos", int'(bus.position), 4);
    chk("up4_dir", int'(bus.dir), 0);
    chk("up4_steps", n_steps - s0, 4);
    chk("up4_wraps", n_wraps - w0, 0);

    // Wrap down from 0 then back up through 0.
    pulse_clear(2'b00);
    idle(2);
    w0 = n_wraps;
    drive(2'b11);
    idle(3);
    chk("wrapdn_pos", int'(bus.position), 255);
    chk("wrapdn_dir", int'(bus.dir), 1);
    chk("wrapdn_cnt", n_wraps - w0, 1);
    drive(2'b00);
    idle(3);
    chk("wrapup_pos", int'(bus.position), 0);
    chk("wrapup_dir", int'(bus.dir), 0);
    chk("wrapup_cnt", n_wraps - w0, 2);

    // Get to position 2 at code 01, then an illegal jump.
    drive(2'b11);
    idle(3);
    pulse_clear(2'b11);
    idle(2);
    drive(2'b00); drive(2'b01);
    idle(3);
    chk("pre_ill_pos", int'(bus.position), 2);
    drive(2'b11);
    idle(3);
    chk("ill_err", int'(bus.error), 1);
    chk("ill_pos", int'(bus.position), 2);
    drive(2'b10); drive(2'b01);
    idle(3);
    chk("fault_pos", int'(bus.position), 2);
    chk("fault_err", int'(bus.error), 1);
    pulse_clear(2'b11);
    #1;
    chk("clr_pos", int'(bus.position), 0);
    chk("clr_err", int'(bus.error), 0);
    idle(2);
    drive(2'b00);
    idle(3);
    chk("post_clr_pos", int'(bus.position), 1);

    // Asynchronous reset mid-cycle at position 3.
    drive(2'b01); drive(2'b10);
    idle(3);
    chk("pre_rst_pos", int'(bus.position), 3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pos", int'(bus.position), 0);
    chk("arst_dir", int'(bus.dir), 0);
    chk("arst_step", int'(bus.step), 0);
    chk("arst_wrap", int'(bus.wrap), 0);
    chk("arst_err", int'(bus.error), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clear coinciding with an up-step decode at position 5.
    idle(4);
    drive(2'b11); drive(2'b00); drive(2'b01); drive(2'b10); drive(2'b11);
    idle(3);
    chk("pre_cs_pos", int'(bus.position), 5);
    drive(2'b00);
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    #1;
    chk("cs_pos", int'(bus.position), 0);
    chk("cs_step", int'(bus.step), 0);
    idle(3);
    chk("cs_pos_hold", int'(bus.position), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
